// File: rtl/stage_sequencer_pkg.sv
// rtl/stage_sequencer_pkg.sv - shared state encodings for the stage sequencer
// Purpose: FSM state type and width used by stage_sequencer.
// Ports: none (package).
package stage_sequencer_pkg;

   localparam int SEQ_STATE_BITS = 1;

   typedef enum logic [SEQ_STATE_BITS-1:0] {
      SEQ_STATE_IDLE = 1'b0,
      SEQ_STATE_RUN  = 1'b1
   } seq_state_t;

endpackage

// File: rtl/stage_sequencer_read_credit_counter.sv
// rtl/stage_sequencer_read_credit_counter.sv - credit counter for TX reads awaiting RX replies
// Purpose: counts reads in flight, saturating at MAX_OUTSTANDING and 0.
// Ports: clk, reset (sync, active-high); inc (read started), dec (reply done);
//        count (reads in flight), not_full (count < MAX_OUTSTANDING).
module read_credit_counter #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int CW = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] count,
   output logic          not_full
);

   localparam logic [CW-1:0] FULL = CW'(MAX_OUTSTANDING);

   logic full;
   logic empty;

   assign full     = (count == FULL);
   assign empty    = (count == '0);
   assign not_full = !full;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else begin
         // A simultaneous start and reply hand one credit straight back.
         if (inc && !dec && !full)
            count <= count + 1'b1;
         else if (dec && !inc && !empty)
            count <= count - 1'b1;

         assert (!(inc && !dec && full));
         assert (!(dec && !inc && empty));
      end
   end

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - per-instruction ALU stage sequencer with repeat stage and read credits
// Purpose: steps an accepted instruction through the stages selected by stage_mask,
//          repeating REPEAT_STAGE repeat_count times; gates imm16 prefetch and
//          tracks outstanding TX reads.
// Ports: decoder side (inst_valid, skip_inst, need_imm16, imm16_loaded, load_imm16,
//        stage_mask, reply_mask, repeat_count, inst_done); ALU side (op_done, alu_en,
//        stage, stage_iter, last_iter); TX/RX side (tx_read_started, rx_done,
//        rx_data_valid, read_slot_free, outstanding).
module stage_sequencer
   import stage_sequencer_pkg::*;
#(
   parameter int NUM_STAGES      = 4,
   parameter int REPEAT_STAGE    = 3,
   parameter int REPEAT_BITS     = 4,
   parameter int MAX_OUTSTANDING = 2,
   parameter int STAGE_W         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
   parameter int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   inst_valid,
   input  logic                   skip_inst,
   input  logic                   need_imm16,
   input  logic                   imm16_loaded,
   output logic                   load_imm16,
   input  logic [NUM_STAGES-1:0]  stage_mask,
   input  logic [NUM_STAGES-1:0]  reply_mask,
   input  logic [REPEAT_BITS-1:0] repeat_count,
   input  logic                   op_done,
   output logic                   alu_en,
   output logic [STAGE_W-1:0]     stage,
   output logic [REPEAT_BITS-1:0] stage_iter,
   output logic                   last_iter,
   output logic                   inst_done,
   input  logic                   tx_read_started,
   input  logic                   rx_done,
   input  logic                   rx_data_valid,
   output logic                   read_slot_free,
   output logic [OUT_W-1:0]       outstanding
);

   // Returns {found, index} of the lowest set bit of m at or above lo.
   function automatic logic [STAGE_W:0] find_from(input logic [NUM_STAGES-1:0] m, input int lo);
      logic [STAGE_W:0] r;
      r = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--)
         if (i >= lo && m[i])
            r = {1'b1, STAGE_W'(i)};
      return r;
   endfunction

   seq_state_t               state, state_n;
   logic [STAGE_W-1:0]       stage_n;
   logic [REPEAT_BITS-1:0]   iter_n;
   logic                     imm16_avail;
   logic                     abort;
   logic                     ready;
   logic [NUM_STAGES-1:0]    eff;
   logic [STAGE_W:0]         first_hit;
   logic [STAGE_W:0]         next_hit;

   always_comb begin
      eff = stage_mask;
      if (repeat_count == '0)
         eff[REPEAT_STAGE] = 1'b0;
   end

   assign first_hit  = find_from(eff, 0);
   assign next_hit   = find_from(eff, int'(stage) + 1);
   assign load_imm16 = inst_valid && need_imm16 && !imm16_avail;
   assign ready      = !load_imm16;

   always_comb begin
      state_n   = state;
      stage_n   = stage;
      iter_n    = stage_iter;
      alu_en    = 1'b0;
      last_iter = 1'b0;
      inst_done = 1'b0;
      abort     = 1'b0;
      case (state)
         SEQ_STATE_IDLE: begin
            if (inst_valid && ready) begin
               if (skip_inst || eff == '0) begin
                  inst_done = 1'b1;
               end else begin
                  state_n = SEQ_STATE_RUN;
                  stage_n = first_hit[STAGE_W-1:0];
                  iter_n  = '0;
               end
            end
         end
         SEQ_STATE_RUN: begin
            last_iter = (stage != STAGE_W'(REPEAT_STAGE)) ||
                        (({1'b0, stage_iter} + 1'b1) == {1'b0, repeat_count});
            if (!inst_valid) begin
               // Decoder dropped the instruction mid-flight: abandon it silently.
               abort   = 1'b1;
               state_n = SEQ_STATE_IDLE;
               stage_n = '0;
               iter_n  = '0;
            end else begin
               alu_en = !(reply_mask[stage] && !rx_data_valid);
               if (op_done) begin
                  if (!last_iter) begin
                     iter_n = stage_iter + 1'b1;
                  end else if (next_hit[STAGE_W]) begin
                     stage_n = next_hit[STAGE_W-1:0];
                     iter_n  = '0;
                  end else begin
                     inst_done = 1'b1;
                     state_n   = SEQ_STATE_IDLE;
                     stage_n   = '0;
                     iter_n    = '0;
                  end
               end
            end
         end
         default: state_n = SEQ_STATE_IDLE;
      endcase
      // A reset cycle never retires an instruction.
      if (reset)
         inst_done = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= SEQ_STATE_IDLE;
         stage       <= '0;
         stage_iter  <= '0;
         imm16_avail <= 1'b0;
      end else begin
         state      <= state_n;
         stage      <= stage_n;
         stage_iter <= iter_n;
         if (inst_done || abort)
            imm16_avail <= 1'b0;
         else if (imm16_loaded)
            imm16_avail <= 1'b1;
      end
   end

   read_credit_counter #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CW              (OUT_W)
   ) u_credit (
      .clk      (clk),
      .reset    (reset),
      .inc      (tx_read_started),
      .dec      (rx_done),
      .count    (outstanding),
      .not_full (read_slot_free)
   );

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - directed self-checking bench for stage_sequencer
module tb_stage_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       inst_valid, skip_inst, need_imm16, imm16_loaded, load_imm16;
   logic [3:0] stage_mask, reply_mask, repeat_count;
   logic       op_done, alu_en, last_iter, inst_done;
   logic [1:0] stage;
   logic [3:0] stage_iter;
   logic       tx_read_started, rx_done, rx_data_valid, read_slot_free;
   logic [1:0] outstanding;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   stage_sequencer #(
      .NUM_STAGES(4), .REPEAT_STAGE(3), .REPEAT_BITS(4), .MAX_OUTSTANDING(2)
   ) dut (
      .clk(clk), .reset(reset), .inst_valid(inst_valid), .skip_inst(skip_inst),
      .need_imm16(need_imm16), .imm16_loaded(imm16_loaded), .load_imm16(load_imm16),
      .stage_mask(stage_mask), .reply_mask(reply_mask), .repeat_count(repeat_count),
      .op_done(op_done), .alu_en(alu_en), .stage(stage), .stage_iter(stage_iter),
      .last_iter(last_iter), .inst_done(inst_done), .tx_read_started(tx_read_started),
      .rx_done(rx_done), .rx_data_valid(rx_data_valid), .read_slot_free(read_slot_free),
      .outstanding(outstanding)
   );

   // Advance to 1 time unit after the next rising edge; inputs change and
   // outputs are checked there, well away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      inst_valid = 0; skip_inst = 0; need_imm16 = 0; imm16_loaded = 0;
      stage_mask = 0; reply_mask = 0; repeat_count = 4'd1; op_done = 0;
      tx_read_started = 0; rx_done = 0; rx_data_valid = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1;
      step(); step();
      reset = 0;
      #1;
      tests++; if (stage !== 2'd0) begin fails++; $display("FAIL reset_stage got %0d exp 0", stage); end
      tests++; if (stage_iter !== 4'd0) begin fails++; $display("FAIL reset_iter got %0d exp 0", stage_iter); end
      tests++; if ({alu_en, inst_done, load_imm16, last_iter} !== 4'b0000) begin fails++; $display("FAIL reset_outs got %b exp 0000", {alu_en, inst_done, load_imm16, last_iter}); end
      tests++; if (outstanding !== 2'd0) begin fails++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
      tests++; if (read_slot_free !== 1'b1) begin fails++; $display("FAIL reset_slot_free got %b exp 1", read_slot_free); end
   endtask

   task automatic test_basic();
      stage_mask = 4'b0101; inst_valid = 1;                  // cycle 0
      #1;
      tests++; if ({alu_en, inst_done} !== 2'b00) begin fails++; $display("FAIL basic_c0 got %b exp 00", {alu_en, inst_done}); end
      step();                                                // cycle 1
      tests++; if (alu_en !== 1'b1 || stage !== 2'd0) begin fails++; $display("FAIL basic_c1 got alu_en=%b stage=%0d exp 1/0", alu_en, stage); end
      tests++; if (last_iter !== 1'b1) begin fails++; $display("FAIL basic_last got %b exp 1", last_iter); end
      step(); step(); op_done = 1;                           // cycle 3
      #1;
      tests++; if (inst_done !== 1'b0) begin fails++; $display("FAIL basic_c3_done got %b exp 0", inst_done); end
      step(); op_done = 0;                                   // cycle 4
      #1;
      tests++; if (stage !== 2'd2) begin fails++; $display("FAIL basic_c4_stage got %0d exp 2", stage); end
      step(); step(); op_done = 1;                           // cycle 6
      #1;
      tests++; if (inst_done !== 1'b1) begin fails++; $display("FAIL basic_c6_done got %b exp 1", inst_done); end
      step(); op_done = 0; inst_valid = 0;                   // cycle 7
      #1;
      tests++; if ({inst_done, alu_en, stage} !== 4'b0000) begin fails++; $display("FAIL basic_c7 got %b exp 0000", {inst_done, alu_en, stage}); end
      clear_inputs();
   endtask

   task automatic test_imm16();
      stage_mask = 4'b0001; need_imm16 = 1; inst_valid = 1;
      for (int c = 0; c < 5; c++) begin
         #1;
         tests++; if (load_imm16 !== 1'b1 || inst_done !== 1'b0) begin fails++; $display("FAIL imm_wait_c%0d got load=%b done=%b exp 1/0", c, load_imm16, inst_done); end
         step();
      end
      imm16_loaded = 1;                                      // cycle 5
      #1;
      tests++; if (load_imm16 !== 1'b1) begin fails++; $display("FAIL imm_c5 got %b exp 1", load_imm16); end
      step(); imm16_loaded = 0;                              // cycle 6
      #1;
      tests++; if (load_imm16 !== 1'b0 || alu_en !== 1'b0) begin fails++; $display("FAIL imm_c6 got load=%b alu=%b exp 0/0", load_imm16, alu_en); end
      step();                                                // cycle 7
      tests++; if (alu_en !== 1'b1 || stage !== 2'd0) begin fails++; $display("FAIL imm_c7 got alu=%b stage=%0d exp 1/0", alu_en, stage); end
      op_done = 1;
      #1;
      tests++; if (inst_done !== 1'b1) begin fails++; $display("FAIL imm_done got %b exp 1", inst_done); end
      step(); op_done = 0;
      #1;
      tests++; if (load_imm16 !== 1'b1) begin fails++; $display("FAIL imm_avail_cleared got load=%b exp 1", load_imm16); end
      clear_inputs();
      step();
   endtask

   task automatic test_skip();
      skip_inst = 1; stage_mask = 4'b0001; inst_valid = 1;
      #1;
      tests++; if (inst_done !== 1'b1 || alu_en !== 1'b0) begin fails++; $display("FAIL skip_plain got done=%b alu=%b exp 1/0", inst_done, alu_en); end
      step(); inst_valid = 0;
      step();
      need_imm16 = 1; inst_valid = 1; imm16_loaded = 1;
      #1;
      tests++; if (inst_done !== 1'b0 || load_imm16 !== 1'b1) begin fails++; $display("FAIL skip_imm_wait got done=%b load=%b exp 0/1", inst_done, load_imm16); end
      step(); imm16_loaded = 0;
      #1;
      tests++; if (inst_done !== 1'b1 || alu_en !== 1'b0) begin fails++; $display("FAIL skip_imm_done got done=%b alu=%b exp 1/0", inst_done, alu_en); end
      step(); clear_inputs();
      step();
   endtask

   task automatic test_repeat();
      stage_mask = 4'b1000; repeat_count = 4'd3; inst_valid = 1;
      step(); op_done = 1;
      for (int k = 0; k < 3; k++) begin
         #1;
         tests++; if (stage !== 2'd3 || stage_iter !== 4'(k)) begin fails++; $display("FAIL rep_iter%0d got stage=%0d iter=%0d exp 3/%0d", k, stage, stage_iter, k); end
         tests++; if (last_iter !== (k == 2) || inst_done !== (k == 2)) begin fails++; $display("FAIL rep_last%0d got last=%b done=%b exp %b", k, last_iter, inst_done, k == 2); end
         step();
      end
      op_done = 0; inst_valid = 0;
      step();
      repeat_count = 4'd0; inst_valid = 1;
      #1;
      tests++; if (inst_done !== 1'b1) begin fails++; $display("FAIL rep_zero got %b exp 1", inst_done); end
      step(); clear_inputs();
      step();
   endtask

   task automatic test_reply();
      stage_mask = 4'b0001; reply_mask = 4'b0001; inst_valid = 1;
      step(); step();
      tests++; if (alu_en !== 1'b0) begin fails++; $display("FAIL reply_wait got %b exp 0", alu_en); end
      rx_data_valid = 1;
      #1;
      tests++; if (alu_en !== 1'b1) begin fails++; $display("FAIL reply_rx1 got %b exp 1", alu_en); end
      step(); rx_data_valid = 0;
      #1;
      tests++; if (alu_en !== 1'b0) begin fails++; $display("FAIL reply_rx0 got %b exp 0", alu_en); end
      step(); rx_data_valid = 1; op_done = 1;
      #1;
      tests++; if (alu_en !== 1'b1 || inst_done !== 1'b1) begin fails++; $display("FAIL reply_end got alu=%b done=%b exp 1/1", alu_en, inst_done); end
      step(); clear_inputs();
      step();
   endtask

   task automatic test_credits();
      tx_read_started = 1;
      step(); step();
      tx_read_started = 0;
      tests++; if (outstanding !== 2'd2 || read_slot_free !== 1'b0) begin fails++; $display("FAIL cred_full got %0d/%b exp 2/0", outstanding, read_slot_free); end
      tx_read_started = 1; rx_done = 1;
      step();
      tx_read_started = 0; rx_done = 0;
      tests++; if (outstanding !== 2'd2) begin fails++; $display("FAIL cred_both got %0d exp 2", outstanding); end
      rx_done = 1;
      step();
      rx_done = 0;
      tests++; if (outstanding !== 2'd1 || read_slot_free !== 1'b1) begin fails++; $display("FAIL cred_dec got %0d/%b exp 1/1", outstanding, read_slot_free); end
   endtask

   task automatic test_reset_mid_run();
      stage_mask = 4'b0001; inst_valid = 1;
      step();
      tests++; if (alu_en !== 1'b1) begin fails++; $display("FAIL rst_run got alu=%b exp 1", alu_en); end
      reset = 1; op_done = 1;
      #1;
      tests++; if (inst_done !== 1'b0) begin fails++; $display("FAIL rst_no_done got %b exp 0", inst_done); end
      step(); reset = 0; op_done = 0;
      #1;
      tests++; if (alu_en !== 1'b0 || outstanding !== 2'd0 || inst_done !== 1'b0) begin fails++; $display("FAIL rst_idle got alu=%b out=%0d done=%b exp 0/0/0", alu_en, outstanding, inst_done); end
      step(); clear_inputs();
      step();
   endtask

   task automatic test_back_to_back();
      stage_mask = 4'b0001; inst_valid = 1;
      step(); op_done = 1;
      #1;
      tests++; if (inst_done !== 1'b1) begin fails++; $display("FAIL b2b_first got %b exp 1", inst_done); end
      step(); op_done = 0; stage_mask = 4'b0010;
      #1;
      tests++; if (alu_en !== 1'b0 || inst_done !== 1'b0) begin fails++; $display("FAIL b2b_accept got alu=%b done=%b exp 0/0", alu_en, inst_done); end
      step();
      tests++; if (alu_en !== 1'b1 || stage !== 2'd1) begin fails++; $display("FAIL b2b_second got alu=%b stage=%0d exp 1/1", alu_en, stage); end
      op_done = 1;
      #1;
      tests++; if (inst_done !== 1'b1) begin fails++; $display("FAIL b2b_done got %b exp 1", inst_done); end
      step(); clear_inputs();
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_imm16();
      test_skip();
      test_repeat();
      test_reply();
      test_credits();
      test_reset_mid_run();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
